// File: rtl/cic3_pkg.sv
// Shared constants and state type for the CIC3 row readout serializer.
package cic3_pkg;

    localparam int DATA_WIDTH             = 25;
    localparam int NUM_FILTERS_SUBSECTION = 12;
    localparam int NUM_SUBSECTIONS        = 2;
    localparam int NUM_CH                 = NUM_FILTERS_SUBSECTION * NUM_SUBSECTIONS;
    localparam int CH_W                   = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } readout_state_e;

endpackage

// File: rtl/cic3_edge_detect.sv
// Two-stage register of the row decimation clock; tick_o pulses for one clk
// cycle after each rising edge of sig_i.
module cic3_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig_i,
    output logic tick_o
);

    logic d1_q;
    logic d2_q;

    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample the pre-edge values and form a true two-register pipeline.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d1_q <= 1'b0;
            d2_q <= 1'b0;
        end else begin
            d1_q <= sig_i;
            d2_q <= d1_q;
        end
    end

    assign tick_o = d1_q & ~d2_q;

endmodule

// File: rtl/cic3_row_readout.sv
// Captures a full row of CIC3 filter outputs on each decimation tick and
// streams the words out one channel at a time over a valid/ready handshake.
module cic3_row_readout #(
    parameter int NUM_FILTERS_SUBSECTION = cic3_pkg::NUM_FILTERS_SUBSECTION,
    parameter int NUM_SUBSECTIONS        = cic3_pkg::NUM_SUBSECTIONS,
    parameter int DATA_WIDTH             = cic3_pkg::DATA_WIDTH
) (
    input  logic                                                     clk,
    input  logic                                                     reset_n,
    input  logic                                                     divided_clk,
    input  logic [NUM_FILTERS_SUBSECTION*NUM_SUBSECTIONS*DATA_WIDTH-1:0] in_data,
    input  logic                                                     enable,
    output logic [DATA_WIDTH-1:0]                                    out_data,
    output logic [cic3_pkg::CH_W-1:0]                                out_chan,
    output logic                                                     out_valid,
    input  logic                                                     out_ready,
    output logic                                                     out_first,
    output logic                                                     out_last,
    output logic [7:0]                                               frame_id,
    output logic [7:0]                                               overrun_cnt,
    input  logic                                                     clear_overrun
);

    import cic3_pkg::readout_state_e;
    import cic3_pkg::ST_IDLE;
    import cic3_pkg::ST_STREAM;
    import cic3_pkg::CH_W;

    localparam int              NUM_CH  = NUM_FILTERS_SUBSECTION * NUM_SUBSECTIONS;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    readout_state_e        state_q;
    logic [DATA_WIDTH-1:0] snap_q [NUM_CH];
    logic [DATA_WIDTH-1:0] in_words [NUM_CH];
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]       out_chan_q;
    logic                  out_valid_q;
    logic                  out_first_q;
    logic                  out_last_q;
    logic [7:0]            frame_id_q;
    logic [7:0]            overrun_q;

    logic            tick;
    logic            xfer;
    logic            xfer_last;
    logic            capture;
    logic            load;
    logic            drop;
    logic [CH_W-1:0] chan_nxt;

    cic3_edge_detect u_edge_detect (
        .clk     (clk),
        .reset_n (reset_n),
        .sig_i   (divided_clk),
        .tick_o  (tick)
    );

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign in_words[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // out_chan_q doubles as the read index into the snapshot.
    assign xfer      = (state_q == ST_STREAM) && out_ready;
    assign xfer_last = xfer && (out_chan_q == LAST_CH);
    assign capture   = tick && enable;
    assign load      = capture && ((state_q == ST_IDLE) || xfer_last);
    assign drop      = capture && (state_q == ST_STREAM) && !xfer_last;
    assign chan_nxt  = out_chan_q + CH_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            // NOTE: the snapshot array is reset explicitly because a frame
            // aborted by reset must never leak stale words to the output.
            for (int k = 0; k < NUM_CH; k++) snap_q[k] <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_id_q  <= '0;
            overrun_q   <= '0;
        end else begin
            if (load) begin
                state_q     <= ST_STREAM;
                snap_q      <= in_words;
                out_data_q  <= in_words[0];
                out_chan_q  <= '0;
                out_valid_q <= 1'b1;
                out_first_q <= 1'b1;
                out_last_q  <= (NUM_CH == 1);
                frame_id_q  <= frame_id_q + 8'd1;
            end else if (xfer_last) begin
                state_q     <= ST_IDLE;
                out_valid_q <= 1'b0;
                out_first_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else if (xfer) begin
                out_data_q  <= snap_q[chan_nxt];
                out_chan_q  <= chan_nxt;
                out_first_q <= 1'b0;
                out_last_q  <= (chan_nxt == LAST_CH);
            end

            // A clear that coincides with a drop still records that drop.
            if (clear_overrun) begin
                overrun_q <= drop ? 8'd1 : 8'd0;
            end else if (drop && (overrun_q != 8'hFF)) begin
                overrun_q <= overrun_q + 8'd1;
            end
        end
    end

    assign out_data    = out_data_q;
    assign out_chan    = out_chan_q;
    assign out_valid   = out_valid_q;
    assign out_first   = out_first_q;
    assign out_last    = out_last_q;
    assign frame_id    = frame_id_q;
    assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_cic3_row_readout.sv
// Self-checking bench for cic3_row_readout: directed scenarios with random
// data, compared against a frame-level reference model kept in the bench.
module tb_cic3_row_readout;

    localparam int DW     = cic3_pkg::DATA_WIDTH;
    localparam int NUM_CH = cic3_pkg::NUM_CH;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 divided_clk;
    logic [NUM_CH*DW-1:0] in_data;
    logic                 enable;
    logic [DW-1:0]        out_data;
    logic [4:0]           out_chan;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_first;
    logic                 out_last;
    logic [7:0]           frame_id;
    logic [7:0]           overrun_cnt;
    logic                 clear_overrun;

    int checks = 0;
    int errors = 0;

    // Reference model: the captured row, read position, and counters.
    int            m_snap [NUM_CH];
    int            m_pos;
    bit            m_busy;
    logic [7:0]    m_fid;
    int            m_ovr;
    bit            m_p1, m_p2;
    logic [DW-1:0] got_q [$];

    cic3_row_readout dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .divided_clk   (divided_clk),
        .in_data       (in_data),
        .enable        (enable),
        .out_data      (out_data),
        .out_chan      (out_chan),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_first     (out_first),
        .out_last      (out_last),
        .frame_id      (frame_id),
        .overrun_cnt   (overrun_cnt),
        .clear_overrun (clear_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ramp();
        for (int k = 0; k < NUM_CH; k++) in_data[k*DW +: DW] = DW'(k * 1000);
    endtask

    task automatic set_random();
        for (int k = 0; k < NUM_CH; k++) in_data[k*DW +: DW] = DW'($urandom);
    endtask

    // One clk cycle: apply current inputs, advance the model, compare outputs.
    task automatic step();
        bit            stall, tick, xfer, lastx, cap, drop;
        logic [DW-1:0] s_data;
        logic [4:0]    s_chan;
        logic          s_first, s_last;
        stall   = out_valid && !out_ready;
        s_data  = out_data;
        s_chan  = out_chan;
        s_first = out_first;
        s_last  = out_last;
        if (out_valid && out_ready) got_q.push_back(out_data);
        @(posedge clk);
        tick  = m_p1 && !m_p2;
        xfer  = m_busy && out_ready;
        lastx = xfer && (m_pos == NUM_CH - 1);
        cap   = tick && enable;
        drop  = cap && m_busy && !lastx;
        if (cap && (!m_busy || lastx)) begin
            for (int k = 0; k < NUM_CH; k++) m_snap[k] = int'(in_data[k*DW +: DW]);
            m_pos  = 0;
            m_busy = 1'b1;
            m_fid  = m_fid + 8'd1;
        end else if (xfer) begin
            if (lastx) m_busy = 1'b0;
            else       m_pos++;
        end
        if (clear_overrun)          m_ovr = drop ? 1 : 0;
        else if (drop && m_ovr < 255) m_ovr++;
        m_p2 = m_p1;
        m_p1 = divided_clk;
        #1;
        check("valid", 32'(out_valid), 32'(m_busy));
        if (m_busy) begin
            check("chan", 32'(out_chan), 32'(m_pos));
            check("data", 32'(out_data), 32'(m_snap[m_pos]));
            check("first", 32'(out_first), 32'(m_pos == 0));
            check("last", 32'(out_last), 32'(m_pos == NUM_CH - 1));
        end
        check("frame_id", 32'(frame_id), 32'(m_fid));
        check("overrun", 32'(overrun_cnt), 32'(m_ovr));
        if (stall) begin
            check("stall_data", 32'(out_data), 32'(s_data));
            check("stall_chan", 32'(out_chan), 32'(s_chan));
            check("stall_fl", {30'd0, out_first, out_last}, {30'd0, s_first, s_last});
        end
    endtask

    task automatic rise(input int hi, input int lo);
        divided_clk = 1'b1;
        repeat (hi) step();
        divided_clk = 1'b0;
        repeat (lo) step();
    endtask

    // Asynchronous reset, checked immediately before any clock edge.
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_data", 32'(out_data), 0);
        check("rst_chan", 32'(out_chan), 0);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_fl", {30'd0, out_first, out_last}, 0);
        check("rst_fid", 32'(frame_id), 0);
        check("rst_ovr", 32'(overrun_cnt), 0);
        m_busy = 1'b0; m_pos = 0; m_fid = '0; m_ovr = 0; m_p1 = 1'b0; m_p2 = 1'b0;
        for (int k = 0; k < NUM_CH; k++) m_snap[k] = 0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        got_q.delete();
    endtask

    initial begin
        divided_clk   = 1'b0;
        enable        = 1'b1;
        out_ready     = 1'b1;
        clear_overrun = 1'b0;
        in_data       = '0;
        reset_n       = 1'b1;
        #2;
        do_reset();

        // Ramp row, single decimation edge, free-flowing sink.
        set_ramp();
        rise(3, 40);
        check("ramp_count", 32'(got_q.size()), 32'(NUM_CH));
        for (int k = 0; k < NUM_CH && k < got_q.size(); k++)
            check("ramp_word", 32'(got_q[k]), 32'(k * 1000));
        check("ramp_fid", 32'(frame_id), 1);

        // Random backpressure: every word delivered once, stable while stalled.
        do_reset();
        set_random();
        divided_clk = 1'b1;
        for (int i = 0; i < 400 && (i < 5 || m_busy); i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (i == 3) divided_clk = 1'b0;
            step();
        end
        check("bp_done", 32'(m_busy), 0);
        check("bp_count", 32'(got_q.size()), 32'(NUM_CH));
        for (int k = 0; k < NUM_CH && k < got_q.size(); k++)
            check("bp_word", 32'(got_q[k]), 32'(m_snap[k]));

        // Held-off sink across three more edges: three drops, snapshot intact.
        do_reset();
        set_ramp();
        out_ready = 1'b0;
        rise(3, 5);
        set_random();
        repeat (3) rise(3, 5);
        check("ovr_cnt", 32'(overrun_cnt), 3);
        check("ovr_fid", 32'(frame_id), 1);
        check("ovr_ch0", 32'(out_data), 0);
        out_ready = 1'b1;
        repeat (30) step();
        check("ovr_last_word", 32'(got_q.size() == NUM_CH ? got_q[NUM_CH-1] : '0), 23000);

        // Edge coinciding with the final transfer reloads without a bubble.
        do_reset();
        set_ramp();
        out_ready = 1'b1;
        rise(3, 0);
        for (int i = 0; i < 40 && !(m_busy && m_pos == NUM_CH - 2); i++) step();
        check("b2b_reach", 32'(m_pos), 32'(NUM_CH - 2));
        set_random();
        divided_clk = 1'b1;
        step();
        step();
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_chan", 32'(out_chan), 0);
        check("b2b_data", 32'(out_data), 32'(in_data[DW-1:0]));
        check("b2b_fid", 32'(frame_id), 2);
        divided_clk = 1'b0;
        repeat (30) step();

        // Reset in the middle of a frame, then restart on the next edge.
        do_reset();
        set_ramp();
        rise(3, 0);
        for (int i = 0; i < 40 && !(m_busy && m_pos == 11); i++) step();
        check("mid_reach", 32'(m_pos), 11);
        #1;
        do_reset();
        repeat (8) step();
        set_random();
        rise(3, 30);
        check("mid_fid", 32'(frame_id), 1);
        check("mid_count", 32'(got_q.size()), 32'(NUM_CH));

        // Disabled capture, overrun saturation, clear coinciding with a drop.
        do_reset();
        set_ramp();
        enable = 1'b0;
        rise(3, 5);
        check("dis_idle", 32'(out_valid), 0);
        enable    = 1'b1;
        out_ready = 1'b0;
        rise(3, 3);
        enable = 1'b0;
        rise(3, 3);
        check("dis_ovr", 32'(overrun_cnt), 0);
        enable = 1'b1;
        repeat (300) rise(2, 2);
        check("sat_ovr", 32'(overrun_cnt), 255);
        divided_clk = 1'b1;
        step();
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        divided_clk   = 1'b0;
        check("clr_ovr", 32'(overrun_cnt), 1);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
